ram_slot_arbiter: RTL and testbench

- Sequences the shared ST RAM between the CPU and the DMA requesters: video shifter load, DMA sound and disk/ACSI DMA.
- Also schedules DRAM refresh.
- Divides clk32 into fixed 8-clock memory cycles (4 MHz) and alternates CPU slots with DMA slots.
- Drives RAM strobes, the address-mux owner and a per-requester acknowledge. Sits between the MCU address generators and the RAM/shifter datapath.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arb_refresh.sv | 48 ++++
 rtl/ram_slot_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_slot_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the ST RAM slot arbiter: cycle owners and the
// phase positions of the strobe edges inside an 8-clock memory cycle.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_CPU  = 3'd1,
    OWN_VID  = 3'd2,
    OWN_SND  = 3'd3,
    OWN_DSK  = 3'd4,
    OWN_REF  = 3'd5
  } owner_e;

  localparam logic [2:0] RAM_ON   = 3'd0;
  localparam logic [2:0] RAS_ON   = 3'd1;
  localparam logic [2:0] WE_ON    = 3'd2;
  localparam logic [2:0] LATCH_PH = 3'd5;
  // Every strobe is released on the ack phase, which closes the cycle.
  localparam logic [2:0] ACK_PH   = 3'd7;

  function automatic logic is_data_owner(input owner_e o);
    return (o == OWN_CPU) || (o == OWN_VID) || (o == OWN_SND) || (o == OWN_DSK);
  endfunction

endpackage

// File: rtl/ram_arb_refresh.sv
// Refresh scheduler: counts DMA slots down and raises a sticky refresh
// request every REFRESH_SLOTS slots until a refresh cycle is granted.
module ram_arb_refresh #(
  parameter int REFRESH_SLOTS = 16,
  parameter int REF_CNT_W     = 5
) (
  input  logic clk32,
  input  logic resb,
  input  logic dma_start,
  input  logic ref_grant,
  output logic ref_pend
);

  localparam logic [REF_CNT_W-1:0] RELOAD = REF_CNT_W'(REFRESH_SLOTS - 1);

  logic [REF_CNT_W-1:0] cnt_q;
  logic [REF_CNT_W-1:0] cnt_nx;
  logic                 pend_q;
  logic                 pend_nx;

  always_comb begin
    cnt_nx  = cnt_q;
    pend_nx = pend_q;
    if (dma_start) begin
      cnt_nx = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
    if (ref_grant) begin
      pend_nx = 1'b0;
    end
    // A fresh expiry on the grant edge is a new request, so it wins.
    if (dma_start && (cnt_nx == '0)) begin
      pend_nx = 1'b1;
    end
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nx;
      pend_q <= pend_nx;
    end
  end

  assign ref_pend = pend_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// ST RAM slot arbiter: splits clk32 into 8-clock memory cycles, alternates
// CPU and DMA slots, picks the owner per slot and generates RAM strobes.
//
// owner    | meaning
// ---------+-----------------------------------------------
// OWN_NONE | idle cycle, all strobes inactive
// OWN_CPU  | CPU access, direction from cpu_rw
// OWN_VID  | shifter load (read, latch strobe at phase 5)
// OWN_SND  | DMA sound fetch (read)
// OWN_DSK  | disk/ACSI DMA, direction from dsk_rw
// OWN_REF  | refresh cycle: RAS only, refresh high
module ram_slot_arbiter
  import ram_arb_pkg::*;
#(
  parameter int REFRESH_SLOTS = 16,
  parameter bit CPU_STEAL     = 1'b1,
  parameter int REF_CNT_W     = 5
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic       vid_req,
  input  logic       snd_req,
  input  logic       dsk_req,
  input  logic       dsk_rw,
  output logic [2:0] owner,
  output logic       slot,
  output logic [2:0] phase,
  output logic       ram_n,
  output logic       ras_n,
  output logic       we_n,
  output logic       latch,
  output logic       refresh,
  output logic       cpu_ack,
  output logic       vid_ack,
  output logic       snd_ack,
  output logic       dsk_ack
);

  owner_e owner_q;
  owner_e owner_nx;
  logic   armed_q;
  logic   rd_q;
  logic   rd_nx;
  logic   wrap;
  logic   slot_nx;
  logic [2:0] phase_nx;
  logic   dma_start;
  logic   ref_grant;
  logic   ref_pend;
  logic   data_nx;
  logic   ram_n_nx;
  logic   ras_n_nx;
  logic   we_n_nx;
  logic   latch_nx;
  logic   refresh_nx;
  logic   ack_nx;

  ram_arb_refresh #(
    .REFRESH_SLOTS(REFRESH_SLOTS),
    .REF_CNT_W    (REF_CNT_W)
  ) u_refresh (
    .clk32    (clk32),
    .resb     (resb),
    .dma_start(dma_start),
    .ref_grant(ref_grant),
    .ref_pend (ref_pend)
  );

  always_comb begin
    // The first edge out of reset acts as a wrap so the first cycle is a CPU slot.
    wrap     = !armed_q || (phase == 3'd7);
    phase_nx = wrap ? 3'd0 : phase + 3'd1;
    slot_nx  = wrap ? ~slot : slot;
    owner_nx = owner_q;
    rd_nx    = rd_q;

    if (wrap) begin
      owner_nx = OWN_NONE;
      rd_nx    = 1'b1;
      if (!slot_nx) begin
        if (cpu_req) begin
          owner_nx = OWN_CPU;
          rd_nx    = cpu_rw;
        end
      end else if (vid_req) begin
        owner_nx = OWN_VID;
      end else if (ref_pend) begin
        owner_nx = OWN_REF;
      end else if (snd_req) begin
        owner_nx = OWN_SND;
      end else if (dsk_req) begin
        owner_nx = OWN_DSK;
        rd_nx    = dsk_rw;
      end else if (CPU_STEAL && cpu_req) begin
        owner_nx = OWN_CPU;
        rd_nx    = cpu_rw;
      end
    end

    dma_start = wrap && slot_nx;
    ref_grant = wrap && (owner_nx == OWN_REF);

    // Strobes are computed from next-state so the registered outputs line up with phase.
    data_nx    = is_data_owner(owner_nx);
    ram_n_nx   = !(data_nx && (phase_nx >= RAM_ON) && (phase_nx < ACK_PH));
    ras_n_nx   = !((data_nx || (owner_nx == OWN_REF)) &&
                   (phase_nx >= RAS_ON) && (phase_nx < ACK_PH));
    we_n_nx    = !(data_nx && !rd_nx && (phase_nx >= WE_ON) && (phase_nx < ACK_PH));
    latch_nx   = data_nx && rd_nx && (phase_nx == LATCH_PH);
    refresh_nx = (owner_nx == OWN_REF);
    ack_nx     = (phase_nx == ACK_PH);
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      phase   <= 3'd0;
      slot    <= 1'b1;
      armed_q <= 1'b0;
      owner_q <= OWN_NONE;
      rd_q    <= 1'b1;
      ram_n   <= 1'b1;
      ras_n   <= 1'b1;
      we_n    <= 1'b1;
      latch   <= 1'b0;
      refresh <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      snd_ack <= 1'b0;
      dsk_ack <= 1'b0;
    end else begin
      phase   <= phase_nx;
      slot    <= slot_nx;
      armed_q <= 1'b1;
      owner_q <= owner_nx;
      rd_q    <= rd_nx;
      ram_n   <= ram_n_nx;
      ras_n   <= ras_n_nx;
      we_n    <= we_n_nx;
      latch   <= latch_nx;
      refresh <= refresh_nx;
      cpu_ack <= ack_nx && (owner_nx == OWN_CPU);
      vid_ack <= ack_nx && (owner_nx == OWN_VID);
      snd_ack <= ack_nx && (owner_nx == OWN_SND);
      dsk_ack <= ack_nx && (owner_nx == OWN_DSK);
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Scoreboard bench for ram_slot_arbiter: the driver queues the expected owner
// of each memory cycle, the monitor checks the strobe shape when it completes.
module tb_ram_slot_arbiter;
  import ram_arb_pkg::*;

  logic clk32 = 1'b0;
  logic resb = 1'b0;
  logic cpu_req = 1'b0, cpu_rw = 1'b1, vid_req = 1'b0;
  logic snd_req = 1'b0, dsk_req = 1'b0, dsk_rw = 1'b1;

  logic [2:0] owner, phase;
  logic slot, ram_n, ras_n, we_n, latch, refresh;
  logic cpu_ack, vid_ack, snd_ack, dsk_ack;

  logic [2:0] ns_owner, ns_phase;
  logic ns_slot, ns_ram_n, ns_ras_n, ns_we_n, ns_latch, ns_refresh;
  logic ns_cpu_ack, ns_vid_ack, ns_snd_ack, ns_dsk_ack;

  always #5 clk32 = ~clk32;

  ram_slot_arbiter u_dut (
    .clk32(clk32), .resb(resb), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .vid_req(vid_req), .snd_req(snd_req), .dsk_req(dsk_req), .dsk_rw(dsk_rw),
    .owner(owner), .slot(slot), .phase(phase), .ram_n(ram_n), .ras_n(ras_n),
    .we_n(we_n), .latch(latch), .refresh(refresh), .cpu_ack(cpu_ack),
    .vid_ack(vid_ack), .snd_ack(snd_ack), .dsk_ack(dsk_ack)
  );

  ram_slot_arbiter #(.CPU_STEAL(1'b0)) u_ns (
    .clk32(clk32), .resb(resb), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .vid_req(vid_req), .snd_req(snd_req), .dsk_req(dsk_req), .dsk_rw(dsk_rw),
    .owner(ns_owner), .slot(ns_slot), .phase(ns_phase), .ram_n(ns_ram_n),
    .ras_n(ns_ras_n), .we_n(ns_we_n), .latch(ns_latch), .refresh(ns_refresh),
    .cpu_ack(ns_cpu_ack), .vid_ack(ns_vid_ack), .snd_ack(ns_snd_ack),
    .dsk_ack(ns_dsk_ack)
  );

  typedef struct packed {
    logic [2:0] own;
    logic       slot;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_slot = 1'b0;
  logic ns_en = 1'b0;
  int   ns_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One memory cycle: requests are set just before the arbitration edge.
  task automatic cyc(input logic c_req, input logic c_rw, input logic v, input logic s,
                     input logic d, input logic d_rw, input logic [2:0] own, input logic wr);
    exp_t e;
    cpu_req = c_req; cpu_rw = c_rw; vid_req = v; snd_req = s; dsk_req = d; dsk_rw = d_rw;
    e.own = own; e.slot = exp_slot; e.wr = wr;
    exp_q.push_back(e);
    exp_slot = ~exp_slot;
    repeat (8) @(negedge clk32);
  endtask

  // Monitor: accumulates per-phase strobe patterns, checks at phase 7.
  initial begin : monitor
    logic [7:0] ram_p, ras_p, we_p, lat_p, ref_p, ack_p;
    logic [7:0] er, es, ew, el, ef, ea;
    logic [3:0] eack;
    logic       data, isref;
    int         nsamp;
    exp_t       e;
    ram_p = '0; ras_p = '0; we_p = '0; lat_p = '0; ref_p = '0; ack_p = '0; nsamp = 0;
    forever begin
      @(negedge clk32);
      if (phase == 3'd0) begin
        ram_p = '0; ras_p = '0; we_p = '0; lat_p = '0; ref_p = '0; ack_p = '0; nsamp = 0;
      end
      ram_p[phase] = !ram_n;
      ras_p[phase] = !ras_n;
      we_p[phase]  = !we_n;
      lat_p[phase] = latch;
      ref_p[phase] = refresh;
      ack_p[phase] = cpu_ack | vid_ack | snd_ack | dsk_ack;
      nsamp++;
      if (phase == 3'd7 && resb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cycle", 32'd1, 32'd0);
        end else begin
          e     = exp_q.pop_front();
          data  = (e.own == OWN_CPU) || (e.own == OWN_VID) || (e.own == OWN_SND) || (e.own == OWN_DSK);
          isref = (e.own == OWN_REF);
          er    = data ? 8'h7F : 8'h00;
          es    = (data || isref) ? 8'h7E : 8'h00;
          ew    = (data && e.wr) ? 8'h7C : 8'h00;
          el    = (data && !e.wr) ? 8'h20 : 8'h00;
          ef    = isref ? 8'hFF : 8'h00;
          ea    = data ? 8'h80 : 8'h00;
          eack  = (e.own == OWN_CPU) ? 4'b1000 : (e.own == OWN_VID) ? 4'b0100 :
                  (e.own == OWN_SND) ? 4'b0010 : (e.own == OWN_DSK) ? 4'b0001 : 4'b0000;
          chk("owner", 32'(owner), 32'(e.own));
          chk("slot", 32'(slot), 32'(e.slot));
          chk("phase_count", 32'(nsamp), 32'd8);
          chk("ram_n_pattern", 32'(ram_p), 32'(er));
          chk("ras_n_pattern", 32'(ras_p), 32'(es));
          chk("we_n_pattern", 32'(we_p), 32'(ew));
          chk("latch_pattern", 32'(lat_p), 32'(el));
          chk("refresh_pattern", 32'(ref_p), 32'(ef));
          chk("ack_phase", 32'(ack_p), 32'(ea));
          chk("ack_select", 32'({cpu_ack, vid_ack, snd_ack, dsk_ack}), 32'(eack));
        end
      end
    end
  end

  initial begin : ns_counter
    forever begin
      @(negedge clk32);
      if (ns_en && ns_cpu_ack) ns_cnt++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    resb = 1'b0;
    repeat (3) @(negedge clk32);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_slot", 32'(slot), 32'd1);
    chk("rst_owner", 32'(owner), 32'(OWN_NONE));
    chk("rst_strobes", 32'({ram_n, ras_n, we_n}), 32'b111);
    chk("rst_outputs", 32'({latch, refresh, cpu_ack, vid_ack, snd_ack, dsk_ack}), 32'd0);

    // Idle: DMA slots 1..15 empty, refresh in DMA slot 16.
    exp_slot = 1'b0;
    resb = 1'b1;
    repeat (15) begin
      cyc(0, 1, 0, 0, 0, 1, OWN_NONE, 0);
      cyc(0, 1, 0, 0, 0, 1, OWN_NONE, 0);
    end
    cyc(0, 1, 0, 0, 0, 1, OWN_NONE, 0);
    cyc(0, 1, 0, 0, 0, 1, OWN_REF, 0);

    // CPU write: CPU slot, then stolen DMA slot 17.
    cyc(1, 0, 0, 0, 0, 1, OWN_CPU, 1);
    cyc(1, 0, 0, 0, 0, 1, OWN_CPU, 1);

    // DMA priority vid > snd > dsk (dsk write), DMA slots 18..23.
    repeat (2) begin
      cyc(0, 1, 1, 1, 1, 0, OWN_NONE, 0);
      cyc(0, 1, 1, 1, 1, 0, OWN_VID, 0);
    end
    repeat (2) begin
      cyc(0, 1, 0, 1, 1, 0, OWN_NONE, 0);
      cyc(0, 1, 0, 1, 1, 0, OWN_SND, 0);
    end
    repeat (2) begin
      cyc(0, 1, 0, 0, 1, 0, OWN_NONE, 0);
      cyc(0, 1, 0, 0, 1, 0, OWN_DSK, 1);
    end

    // Video holds DMA slots 24..34; refresh expiring at slot 31 waits.
    repeat (11) begin
      cyc(0, 1, 1, 1, 0, 1, OWN_NONE, 0);
      cyc(0, 1, 1, 1, 0, 1, OWN_VID, 0);
    end
    cyc(0, 1, 0, 1, 0, 1, OWN_NONE, 0);
    cyc(0, 1, 0, 1, 0, 1, OWN_REF, 0);
    cyc(0, 1, 0, 1, 0, 1, OWN_NONE, 0);
    cyc(0, 1, 0, 1, 0, 1, OWN_SND, 0);

    // CPU reads alone: stealing instance acks every cycle, the other every second.
    ns_en = 1'b1;
    repeat (4) begin
      cyc(1, 1, 0, 0, 0, 1, OWN_CPU, 0);
      cyc(1, 1, 0, 0, 0, 1, OWN_CPU, 0);
    end
    ns_en = 1'b0;
    chk("nosteal_cpu_acks", 32'(ns_cnt), 32'd4);

    // Reset at phase 4 of a video cycle aborts it.
    cyc(0, 1, 1, 0, 0, 1, OWN_NONE, 0);
    repeat (5) @(negedge clk32);
    chk("abort_phase", 32'(phase), 32'd4);
    chk("abort_owner", 32'(owner), 32'(OWN_VID));
    resb = 1'b0;
    @(negedge clk32);
    chk("abort_strobes", 32'({ram_n, ras_n}), 32'b11);
    chk("abort_no_ack", 32'(vid_ack), 32'd0);
    chk("abort_phase_slot", 32'({phase, slot}), 32'({3'd0, 1'b1}));
    vid_req = 1'b0;
    @(negedge clk32);
    chk("abort_no_ack2", 32'({vid_ack, latch, we_n}), 32'b001);
    exp_slot = 1'b0;
    resb = 1'b1;
    cyc(1, 1, 0, 0, 0, 1, OWN_CPU, 0);
    cyc(0, 1, 0, 0, 1, 1, OWN_DSK, 0);
    cyc(0, 1, 0, 0, 0, 1, OWN_NONE, 0);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk32);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
